// File: rtl/lsu_mmio_unit_if.sv
// lsu_mmio_unit_if: bus bundle for lsu_mmio_unit.
//   Core side  : read_en, write_en, func3, address, data_in -> data_out_to_riscv, load_valid, stall
//   Memory side: address_to_mem, data_out_to_mem, cs (active-low), mem_read, mask <- data_from_mem
//   UART side  : data_to_uart, load_uart, transfer_byte <- uart_busy, uart_done
//   misaligned : present only when MISALIGN_TRAP_EN is defined
// slave modport = the LSU, master modport = whatever drives it (core/memory/UART models).
interface lsu_mmio_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  read_en;
   logic                  write_en;
   logic [2:0]            func3;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     data_in;
   logic [DATA_W-1:0]     data_from_mem;
   logic [DATA_W-1:0]     data_out_to_riscv;
   logic                  load_valid;
   logic [ADDR_W-1:0]     address_to_mem;
   logic [DATA_W-1:0]     data_out_to_mem;
   logic                  cs;
   logic                  mem_read;
   logic [DATA_W/8-1:0]   mask;
   logic [7:0]            data_to_uart;
   logic                  load_uart;
   logic                  transfer_byte;
   logic                  uart_busy;
   logic                  uart_done;
   logic                  stall;
`ifdef MISALIGN_TRAP_EN
   logic                  misaligned;
`endif

   modport slave (
      input  read_en, write_en, func3, address, data_in, data_from_mem, uart_busy, uart_done,
      output data_out_to_riscv, load_valid, address_to_mem, data_out_to_mem, cs, mem_read, mask,
             data_to_uart, load_uart, transfer_byte, stall
`ifdef MISALIGN_TRAP_EN
      , output misaligned
`endif
   );

   modport master (
      output read_en, write_en, func3, address, data_in, data_from_mem, uart_busy, uart_done,
      input  data_out_to_riscv, load_valid, address_to_mem, data_out_to_mem, cs, mem_read, mask,
             data_to_uart, load_uart, transfer_byte, stall
`ifdef MISALIGN_TRAP_EN
      , input misaligned
`endif
   );
endinterface

// File: rtl/lsu_mmio_unit.sv
// lsu_mmio_unit: MEM-stage load/store unit between a RISC-V core, a byte-masked
// data memory and a UART transmitter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lsu_mmio_unit_if.slave (core, memory and UART signals)
// Stores to memory complete combinationally in the request cycle. Loads take one
// wait cycle (ST_LWAIT) and the extended result is registered. Stores with
// address[MMIO_BIT]=1 hand one byte to the UART through a stalling FSM.
// Optional macro MISALIGN_TRAP_EN: flags and suppresses misaligned H/W/D accesses
// through bus.misaligned.
module lsu_mmio_unit #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MMIO_BIT = 31
) (
   input  logic            clk,
   input  logic            rst,
   lsu_mmio_unit_if.slave  bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [2:0] {ST_IDLE, ST_LWAIT, ST_UWAIT, ST_ULOAD, ST_UXFER} state_t;
   state_t state, state_nxt;

   logic [OFF_W-1:0]  off;
   logic              is_mmio;
   logic              legal;
   logic              trap;
   logic [NB-1:0]     size_ones;
   logic [DATA_W-1:0] st_masked;
   logic [DATA_W-1:0] st_data;
   logic [NB-1:0]     st_mask;
   logic [7:0]        uart_byte;

   // latched load context and UART byte
   logic [2:0]        ld_f3;
   logic [OFF_W-1:0]  ld_off;
   logic              ld_mmio;
   logic [7:0]        byte_q;
   logic [DATA_W-1:0] dout_q;
   logic              lv_q;
   logic [DATA_W-1:0] ld_shift;
   logic [DATA_W-1:0] ld_res;

   // combinational outputs
   logic              cs_c, mem_read_c, stall_c, load_uart_c, xfer_c;
   logic [NB-1:0]     mask_c;
   logic [DATA_W-1:0] wdata_c;
   logic [7:0]        uart_out_c;
   logic              latch_ld, latch_byte, ld_zero, ld_done;

   assign off     = bus.address[OFF_W-1:0];
   assign is_mmio = bus.address[MMIO_BIT];

   always_comb begin
      case (bus.func3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
         3'b011, 3'b110:                         legal = (DATA_W == 64);
         default:                                legal = 1'b0;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic mis;
   always_comb begin
      case (bus.func3[1:0])
         2'd1:    mis = bus.address[0];
         2'd2:    mis = (bus.address[1:0] != 2'b00);
         2'd3:    mis = (bus.address[2:0] != 3'b000);
         default: mis = 1'b0;
      endcase
   end
   // only meaningful for a legal access that is actually being requested
   assign trap           = (state == ST_IDLE) && (bus.read_en || bus.write_en) && legal && mis;
   assign bus.misaligned = trap;
`else
   assign trap = 1'b0;
`endif

   // size-wide lane ones; D only reaches here when NB=8
   always_comb begin
      case (bus.func3[1:0])
         2'd0:    size_ones = NB'(1);
         2'd1:    size_ones = NB'(3);
         2'd2:    size_ones = NB'(15);
         default: size_ones = '1;
      endcase
   end

   // zero lanes beyond the access size before shifting so unused lanes read 0
   always_comb begin
      st_masked = '0;
      for (int i = 0; i < NB; i++)
         st_masked[i*8 +: 8] = size_ones[i] ? bus.data_in[i*8 +: 8] : 8'h00;
   end
   assign st_data   = st_masked << {off, 3'b000};
   assign st_mask   = size_ones << off;
   assign uart_byte = 8'(bus.data_in >> {off, 3'b000});

   // load alignment and extension, evaluated in ST_LWAIT
   assign ld_shift = bus.data_from_mem >> {ld_off, 3'b000};
   always_comb begin
      ld_res = '0;
      if (ld_mmio) begin
         ld_res[0] = bus.uart_busy;
      end else begin
         case (ld_f3)
            3'b000:  ld_res = DATA_W'($signed(ld_shift[7:0]));
            3'b100:  ld_res = DATA_W'(ld_shift[7:0]);
            3'b001:  ld_res = DATA_W'($signed(ld_shift[15:0]));
            3'b101:  ld_res = DATA_W'(ld_shift[15:0]);
            3'b010:  ld_res = DATA_W'($signed(ld_shift[31:0]));
            3'b110:  ld_res = DATA_W'(ld_shift[31:0]);
            default: ld_res = ld_shift;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      cs_c        = 1'b1;
      mem_read_c  = 1'b1;
      mask_c      = '0;
      wdata_c     = '0;
      stall_c     = 1'b0;
      load_uart_c = 1'b0;
      xfer_c      = 1'b0;
      uart_out_c  = 8'h00;
      latch_ld    = 1'b0;
      latch_byte  = 1'b0;
      ld_zero     = 1'b0;
      ld_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.read_en) begin
               // a load wins over a simultaneous store
               if (!legal) begin
                  ld_zero = 1'b1;
               end else if (!trap) begin
                  latch_ld  = 1'b1;
                  stall_c   = 1'b1;
                  state_nxt = ST_LWAIT;
                  if (!is_mmio) begin
                     cs_c       = 1'b0;
                     mem_read_c = 1'b0;
                     mask_c     = '1;
                  end
               end
            end else if (bus.write_en && legal && !trap) begin
               if (is_mmio) begin
                  if (bus.func3 == 3'b000) begin
                     latch_byte = 1'b1;
                     stall_c    = 1'b1;
                     state_nxt  = bus.uart_busy ? ST_UWAIT : ST_ULOAD;
                  end
               end else begin
                  cs_c    = 1'b0;
                  mask_c  = st_mask;
                  wdata_c = st_data;
               end
            end
         end
         ST_LWAIT: begin
            ld_done   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_UWAIT: begin
            stall_c = 1'b1;
            if (!bus.uart_busy) state_nxt = ST_ULOAD;
         end
         ST_ULOAD: begin
            stall_c     = 1'b1;
            load_uart_c = 1'b1;
            xfer_c      = 1'b1;
            uart_out_c  = byte_q;
            state_nxt   = ST_UXFER;
         end
         ST_UXFER: begin
            stall_c    = 1'b1;
            xfer_c     = 1'b1;
            uart_out_c = byte_q;
            if (bus.uart_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ld_f3   <= 3'b000;
         ld_off  <= '0;
         ld_mmio <= 1'b0;
         byte_q  <= 8'h00;
         dout_q  <= '0;
         lv_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         lv_q  <= ld_zero | ld_done;
         if (ld_zero)      dout_q <= '0;
         else if (ld_done) dout_q <= ld_res;
         if (latch_ld) begin
            ld_f3   <= bus.func3;
            ld_off  <= off;
            ld_mmio <= is_mmio;
         end
         if (latch_byte) byte_q <= uart_byte;
      end
   end

   assign bus.data_out_to_riscv = dout_q;
   assign bus.load_valid        = lv_q;
   assign bus.address_to_mem    = bus.address;
   assign bus.data_out_to_mem   = wdata_c;
   assign bus.cs                = cs_c;
   assign bus.mem_read          = mem_read_c;
   assign bus.mask              = mask_c;
   assign bus.data_to_uart      = uart_out_c;
   assign bus.load_uart         = load_uart_c;
   assign bus.transfer_byte     = xfer_c;
   assign bus.stall             = stall_c;
endmodule

// File: tb/tb_lsu_mmio_unit.sv
// Directed bench for lsu_mmio_unit: a 32-bit instance (a) and a 64-bit instance (b).
module tb_lsu_mmio_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   lsu_mmio_unit_if #(.DATA_W(32), .ADDR_W(32)) a ();
   lsu_mmio_unit_if #(.DATA_W(64), .ADDR_W(32)) b ();

   lsu_mmio_unit #(.DATA_W(32), .ADDR_W(32), .MMIO_BIT(31)) u32 (.clk(clk), .rst(rst), .bus(a));
   lsu_mmio_unit #(.DATA_W(64), .ADDR_W(32), .MMIO_BIT(31)) u64 (.clk(clk), .rst(rst), .bus(b));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_a;
      a.read_en = 0; a.write_en = 0; a.func3 = 3'b000; a.address = '0;
      a.data_in = '0; a.data_from_mem = '0; a.uart_done = 0;
   endtask

   task automatic idle_b;
      b.read_en = 0; b.write_en = 0; b.func3 = 3'b000; b.address = '0;
      b.data_in = '0; b.data_from_mem = '0; b.uart_done = 0; b.uart_busy = 0;
   endtask

   // one 32-bit load: request, then supply mem data in ST_LWAIT, then check result
   task automatic load32(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] mem, input logic [31:0] exp);
      a.read_en = 1; a.func3 = f3; a.address = addr;
      settle;
      chk({tag, ".req_stall"}, 64'(a.stall), 64'd1);
      tick;
      a.read_en = 0; a.data_from_mem = mem;
      settle;
      chk({tag, ".wait_stall"}, 64'(a.stall), 64'd0);
      tick;
      chk({tag, ".data"}, 64'(a.data_out_to_riscv), 64'(exp));
      chk({tag, ".valid"}, 64'(a.load_valid), 64'd1);
      idle_a;
   endtask

   initial begin
      idle_a; idle_b; a.uart_busy = 0;
      tick; tick;
      // reset state
      chk("rst.cs", 64'(a.cs), 64'd1);
      chk("rst.mem_read", 64'(a.mem_read), 64'd1);
      chk("rst.mask", 64'(a.mask), 64'd0);
      chk("rst.dout", 64'(a.data_out_to_riscv), 64'd0);
      chk("rst.lv", 64'(a.load_valid), 64'd0);
      chk("rst.uart", {55'd0, a.load_uart, a.data_to_uart}, 64'd0);
      chk("rst.xfer_stall", {62'd0, a.transfer_byte, a.stall}, 64'd0);
      rst = 0;
      tick;

      // T1 SB and wider stores
      a.write_en = 1; a.func3 = 3'b000; a.address = 32'h103; a.data_in = 32'h0000_00A5;
      settle;
      chk("sb.cs", 64'(a.cs), 64'd0);
      chk("sb.mem_read", 64'(a.mem_read), 64'd1);
      chk("sb.mask", 64'(a.mask), 64'b1000);
      chk("sb.data", 64'(a.data_out_to_mem), 64'hA500_0000);
      chk("sb.stall", 64'(a.stall), 64'd0);
      a.func3 = 3'b001; a.address = 32'h2; a.data_in = 32'h1234_ABCD;
      settle;
      chk("sh.mask", 64'(a.mask), 64'b1100);
      chk("sh.data", 64'(a.data_out_to_mem), 64'hABCD_0000);
      a.func3 = 3'b010; a.address = 32'h0; a.data_in = 32'hDEAD_BEEF;
      settle;
      chk("sw.mask", 64'(a.mask), 64'b1111);
      chk("sw.data", 64'(a.data_out_to_mem), 64'hDEAD_BEEF);
      tick; idle_a;

      // T2 loads with extension
      a.read_en = 1; a.func3 = 3'b000; a.address = 32'h102;
      settle;
      chk("lb.req_cs", 64'(a.cs), 64'd0);
      chk("lb.req_rd", 64'(a.mem_read), 64'd0);
      chk("lb.req_mask", 64'(a.mask), 64'b1111);
      idle_a;
      load32("lb", 3'b000, 32'h102, 32'h0080_FF00, 32'hFFFF_FF80);
      tick;
      chk("lb.lv_pulse", 64'(a.load_valid), 64'd0);
      chk("lb.hold", 64'(a.data_out_to_riscv), 64'hFFFF_FF80);
      load32("lbu", 3'b100, 32'h102, 32'h0080_FF00, 32'h0000_0080);
      load32("lh", 3'b001, 32'h2, 32'h8001_0000, 32'hFFFF_8001);
      load32("lhu", 3'b101, 32'h2, 32'h8001_0000, 32'h0000_8001);

      // illegal func3 on 32-bit: no access, no stall, returns 0 with load_valid
      a.read_en = 1; a.func3 = 3'b011; a.address = 32'h0;
      settle;
      chk("ill.stall", 64'(a.stall), 64'd0);
      chk("ill.cs", 64'(a.cs), 64'd1);
      tick; idle_a;
      chk("ill.data", 64'(a.data_out_to_riscv), 64'd0);
      chk("ill.lv", 64'(a.load_valid), 64'd1);

      // read and write together: read wins
      a.write_en = 1; a.data_in = 32'h5555_5555;
      settle;
      chk("rw.mem_read", 64'(a.mem_read), 64'd1);
      idle_a;
      a.write_en = 1;
      load32("rw", 3'b010, 32'h0, 32'h1122_3344, 32'h1122_3344);

      // MMIO load returns uart_busy
      a.uart_busy = 1;
      a.read_en = 1; a.func3 = 3'b010; a.address = 32'h8000_0000;
      settle;
      chk("mld.cs", 64'(a.cs), 64'd1);
      idle_a;
      load32("mld", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001);

      // T4 MMIO SB with uart busy for three cycles
      a.write_en = 1; a.func3 = 3'b000; a.address = 32'h8000_0001; a.data_in = 32'h0000_4100;
      settle;
      chk("t4.req_stall", 64'(a.stall), 64'd1);
      chk("t4.req_cs", 64'(a.cs), 64'd1);
      tick; idle_a;
      settle;
      chk("t4.w1", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b100);
      tick;
      settle;
      chk("t4.w2", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b100);
      tick;
      a.uart_busy = 0;
      settle;
      chk("t4.w3", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b100);
      tick;
      settle;
      chk("t4.load", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b111);
      chk("t4.byte", 64'(a.data_to_uart), 64'h41);
      tick;
      settle;
      chk("t4.xfer", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b101);
      chk("t4.hold", 64'(a.data_to_uart), 64'h41);
      tick;
      a.uart_done = 1;
      settle;
      chk("t4.done_stall", 64'(a.stall), 64'd1);
      tick; a.uart_done = 0;
      settle;
      chk("t4.after", {61'd0, a.stall, a.load_uart, a.transfer_byte}, 64'b000);
      chk("t4.byte_clr", 64'(a.data_to_uart), 64'h0);

      // MMIO SW is ignored
      a.write_en = 1; a.func3 = 3'b010; a.address = 32'h8000_0000;
      settle;
      chk("msw.stall", 64'(a.stall), 64'd0);
      tick; idle_a;
      settle;
      chk("msw.xfer", 64'(a.transfer_byte), 64'd0);

      // T5 reset in ST_UXFER
      a.write_en = 1; a.func3 = 3'b000; a.address = 32'h8000_0000; a.data_in = 32'h0000_0033;
      tick; idle_a;
      tick;
      settle;
      chk("t5.in_xfer", 64'(a.transfer_byte), 64'd1);
      rst = 1;
      tick;
      chk("t5.rst_outs", {53'd0, a.stall, a.transfer_byte, a.load_uart, a.data_to_uart}, 64'd0);
      chk("t5.rst_lv", 64'(a.load_valid), 64'd0);
      rst = 0;
      a.uart_done = 1;
      tick; a.uart_done = 0;
      settle;
      chk("t5.late_done", {62'd0, a.stall, a.transfer_byte}, 64'd0);

      // reset while a load is in ST_LWAIT: no load_valid
      a.read_en = 1; a.func3 = 3'b010; a.address = 32'h0;
      tick; idle_a; a.data_from_mem = 32'h7777_7777;
      rst = 1;
      tick; rst = 0;
      chk("rstld.lv", 64'(a.load_valid), 64'd0);
      tick;
      chk("rstld.lv2", 64'(a.load_valid), 64'd0);
      chk("rstld.dout", 64'(a.data_out_to_riscv), 64'd0);

      // T6 misaligned LW
`ifdef MISALIGN_TRAP_EN
      a.read_en = 1; a.func3 = 3'b010; a.address = 32'h2;
      settle;
      chk("t6.mis", 64'(a.misaligned), 64'd1);
      chk("t6.cs", 64'(a.cs), 64'd1);
      chk("t6.mask", 64'(a.mask), 64'd0);
      chk("t6.stall", 64'(a.stall), 64'd0);
      tick; idle_a;
      tick;
      chk("t6.lv", 64'(a.load_valid), 64'd0);
`else
      a.read_en = 1; a.func3 = 3'b010; a.address = 32'h2;
      settle;
      chk("t6.cs", 64'(a.cs), 64'd0);
      chk("t6.mask", 64'(a.mask), 64'b1111);
      idle_a;
      load32("t6", 3'b010, 32'h2, 32'hAABB_CCDD, 32'h0000_AABB);
`endif

      // T3 and friends on the 64-bit instance
      b.read_en = 1; b.func3 = 3'b110; b.address = 32'h4;
      settle;
      chk("t3.stall", 64'(b.stall), 64'd1);
      chk("t3.mask", 64'(b.mask), 64'hFF);
      tick; b.read_en = 0; b.data_from_mem = 64'h89AB_CDEF_0000_0000;
      tick;
      chk("t3.data", b.data_out_to_riscv, 64'h0000_0000_89AB_CDEF);
      chk("t3.lv", 64'(b.load_valid), 64'd1);
      idle_b;
      b.read_en = 1; b.func3 = 3'b010; b.address = 32'h4;
      tick; b.read_en = 0; b.data_from_mem = 64'h89AB_CDEF_0000_0000;
      tick;
      chk("lw64.data", b.data_out_to_riscv, 64'hFFFF_FFFF_89AB_CDEF);
      idle_b;
      b.write_en = 1; b.func3 = 3'b000; b.address = 32'h5; b.data_in = 64'h0000_0000_0000_0077;
      settle;
      chk("sb64.mask", 64'(b.mask), 64'h20);
      chk("sb64.data", b.data_out_to_mem, 64'h0000_7700_0000_0000);
      b.func3 = 3'b011; b.address = 32'h0; b.data_in = 64'h0123_4567_89AB_CDEF;
      settle;
      chk("sd64.mask", 64'(b.mask), 64'hFF);
      chk("sd64.data", b.data_out_to_mem, 64'h0123_4567_89AB_CDEF);
      tick; idle_b;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
